// File: rtl/ram_readback_streamer.sv
// Reads a block of RAM words into a small FIFO and streams them out lane by lane.
// Define STREAM_REVERSE_EN to allow orient==1 to emit lanes high-to-low.
module ram_readback_streamer #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 48,
  parameter int LANES  = 6,
  parameter int FIFO_D = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic [ADDR_W-1:0]         base_addr,
  input  logic [ADDR_W-1:0]         word_count,
  input  logic                      orient,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic                      ram_rden,
  input  logic [DATA_W-1:0]         ram_q,
  output logic [DATA_W/LANES-1:0]   m_data,
  output logic                      m_valid,
  output logic                      m_last,
  input  logic                      m_ready,
  output logic                      busy,
  output logic                      done
);

  localparam int LANE_W = DATA_W / LANES;
  localparam int IDX_W  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PTR_W  = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
  localparam int CNT_W  = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   base_q;
  logic [ADDR_W-1:0]   total_q;
  logic [ADDR_W-1:0]   issued_q;
  logic [ADDR_W-1:0]   popped_q;
  logic                inflight_q;
  logic [DATA_W-1:0]   fifo_q [FIFO_D];
  logic [PTR_W-1:0]    wr_q;
  logic [PTR_W-1:0]    rd_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [IDX_W-1:0]    idx_q;

  logic [CNT_W-1:0]    occ;
  logic                rd_ok;
  logic                fire;
  logic                lane_end;
  logic                pop;
  logic                push;
  logic                last_word;
  logic [IDX_W-1:0]    lane_sel;
  logic [DATA_W-1:0]   head;

`ifdef STREAM_REVERSE_EN
  logic                orient_q;
`else
  logic                unused_orient;
  assign unused_orient = orient;
`endif

  // Occupancy counts the read still in flight so a full FIFO never overflows.
  assign occ       = cnt_q + {{PTR_W{1'b0}}, inflight_q};
  assign rd_ok     = occ < CNT_W'(FIFO_D);
  assign ram_rden  = (state_q == S_READ) && rd_ok;
  assign ram_addr  = base_q + issued_q;

  assign m_valid   = cnt_q != '0;
  assign fire      = m_valid && m_ready;
  assign lane_end  = idx_q == IDX_W'(LANES - 1);
  assign pop       = fire && lane_end;
  assign push      = inflight_q;
  assign last_word = popped_q == (total_q - ADDR_W'(1));
  assign m_last    = m_valid && lane_end && last_word;
  assign head      = fifo_q[rd_q];

  assign busy      = state_q != S_IDLE;
  assign done      = state_q == S_DONE;

`ifdef STREAM_REVERSE_EN
  assign lane_sel  = orient_q ? (IDX_W'(LANES - 1) - idx_q) : idx_q;
`else
  assign lane_sel  = idx_q;
`endif

  always_comb begin
    m_data = '0;
    if (m_valid) begin
      for (int l = 0; l < LANES; l++) begin
        if (lane_sel == IDX_W'(l)) begin
          m_data = head[l*LANE_W +: LANE_W];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      total_q    <= '0;
      issued_q   <= '0;
      popped_q   <= '0;
      inflight_q <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      for (int i = 0; i < FIFO_D; i++) begin
        fifo_q[i] <= '0;
      end
`ifdef STREAM_REVERSE_EN
      orient_q   <= 1'b0;
`endif
    end else if (abort) begin
      state_q    <= S_IDLE;
      issued_q   <= '0;
      popped_q   <= '0;
      inflight_q <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
    end else begin
      inflight_q <= ram_rden;
      if (ram_rden) begin
        issued_q <= issued_q + ADDR_W'(1);
      end
      if (push) begin
        fifo_q[wr_q] <= ram_q;
        wr_q         <= wr_q + PTR_W'(1);
      end
      if (fire) begin
        idx_q <= lane_end ? '0 : idx_q + IDX_W'(1);
      end
      if (pop) begin
        rd_q     <= rd_q + PTR_W'(1);
        popped_q <= popped_q + ADDR_W'(1);
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase

      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            base_q   <= base_addr;
            total_q  <= word_count;
            issued_q <= '0;
            popped_q <= '0;
            idx_q    <= '0;
`ifdef STREAM_REVERSE_EN
            orient_q <= orient;
`endif
            state_q  <= (word_count == '0) ? S_DONE : S_READ;
          end
        end
        S_READ: begin
          if (ram_rden && (issued_q == total_q - ADDR_W'(1))) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (pop && last_word) begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_readback_streamer.sv
// Self-checking bench for ram_readback_streamer: RAM model, beat queue reference,
// directed scenarios then randomized transfers.
module tb_ram_readback_streamer;

  localparam int AW = 16;
  localparam int DW = 48;
  localparam int LN = 6;
  localparam int LW = 8;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          orient = 1'b0;
  logic          m_ready = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] word_count = '0;
  logic [AW-1:0] ram_addr;
  logic          ram_rden;
  logic [DW-1:0] ram_q = '0;
  logic [LW-1:0] m_data;
  logic          m_valid;
  logic          m_last;
  logic          busy;
  logic          done;

  logic [DW-1:0] mem [0:65535];
  logic [LW-1:0] eq_d [$];
  bit            eq_l [$];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_rden) ram_q <= mem[ram_addr];
  end

  ram_readback_streamer #(
    .ADDR_W(AW), .DATA_W(DW), .LANES(LN), .FIFO_D(FD)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .base_addr(base_addr), .word_count(word_count), .orient(orient),
    .ram_addr(ram_addr), .ram_rden(ram_rden), .ram_q(ram_q),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last),
    .m_ready(m_ready), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: the transfer is just the words base..base+n-1 cut into bytes.
  task automatic build(input logic [AW-1:0] b, input logic [AW-1:0] n,
                       input bit ov);
    bit rev;
    logic [AW-1:0] a;
    logic [DW-1:0] word;
    int ln;
`ifdef STREAM_REVERSE_EN
    rev = ov;
`else
    rev = 1'b0;
    if (ov) rev = 1'b0;
`endif
    eq_d.delete();
    eq_l.delete();
    for (int w = 0; w < int'(n); w++) begin
      a = b + AW'(w);
      word = mem[a];
      for (int k = 0; k < LN; k++) begin
        ln = rev ? (LN - 1 - k) : k;
        eq_d.push_back(word[ln*LW +: LW]);
        eq_l.push_back((w == int'(n) - 1) && (k == LN - 1));
      end
    end
  endtask

  task automatic run(input logic [AW-1:0] b, input logic [AW-1:0] n,
                     input int mode, input int stall, input int abort_at,
                     input bit ov);
    int cyc;
    int reads;
    int beats;
    int last_cyc;
    int first_v;
    bit fin;
    bit pstall;
    logic [LW-1:0] pdata;
    logic plast;
    logic [AW-1:0] ea;
    reads = 0; beats = 0; last_cyc = -1; first_v = -1;
    fin = 0; pstall = 0; pdata = '0; plast = 0;
    build(b, n, ov);
    @(posedge clk); #1;
    base_addr = b; word_count = n; orient = ov; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (!fin && cyc < 3000) begin
      if (cyc <= stall) m_ready = 1'b0;
      else if (mode == 1) m_ready = 1'($urandom_range(0, 1));
      else m_ready = 1'b1;
      if (abort_at >= 0 && beats == abort_at) begin
        abort = 1'b1;
        m_ready = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        m_ready = 1'b0;
        @(negedge clk);
        chk("abort_valid", m_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        repeat (4) begin
          @(negedge clk);
          chk("abort_quiet", {ram_rden, m_valid, done, busy}, 0);
        end
        return;
      end
      @(negedge clk);
      if (cyc == 1 && n != 0) chk("lat_rden", ram_rden, 1);
      if (ram_rden) begin
        ea = b + AW'(reads);
        chk("rd_addr", ram_addr, ea);
        chk("rd_extra", reads < int'(n), 1);
        reads++;
      end
      if (stall >= 8 && cyc == stall)
        chk("stall_reads", reads, (int'(n) < FD) ? int'(n) : FD);
      if (m_valid && first_v < 0) begin
        first_v = cyc;
        if (stall == 0 && mode == 0) chk("lat_valid", cyc, 3);
      end
      if (pstall) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, pdata);
        chk("hold_last", m_last, plast);
      end
      if (mode == 0 && first_v > 0 && cyc > stall && eq_d.size() > 0)
        chk("no_gap", m_valid, 1);
      chk("busy", busy, 1);
      if (m_valid && m_ready) begin
        chk("beat_avail", eq_d.size() > 0, 1);
        if (eq_d.size() > 0) begin
          chk("beat_data", m_data, eq_d[0]);
          chk("beat_last", m_last, eq_l[0]);
          if (eq_l[0]) last_cyc = cyc;
          void'(eq_d.pop_front());
          void'(eq_l.pop_front());
          beats++;
        end
      end
      pstall = m_valid && !m_ready;
      pdata = m_data;
      plast = m_last;
      if (done) begin
        chk("done_empty", eq_d.size(), 0);
        chk("done_lat", cyc, (n == 0) ? 1 : last_cyc + 1);
        fin = 1;
      end
      if (!fin) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    chk("finished", fin, 1);
    chk("reads_total", reads, int'(n));
    @(posedge clk); #1;
    m_ready = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = {16'($urandom), $urandom};
    mem[16'h0010] = 48'h0605_0403_0201;
    mem[16'h0011] = 48'h0C0B_0A09_0807;

    #2;
    chk("rst_outs", {ram_rden, m_valid, m_last, busy, done}, 0);
    chk("rst_data", m_data, 0);
    chk("rst_addr", ram_addr, 0);
    @(negedge clk);
    rst = 1'b1;

    run(16'h0010, 16'd2, 0, 0, -1, 1'b0);
    run(16'h0010, 16'd2, 0, 0, -1, 1'b1);
    run(16'h0040, 16'd0, 0, 0, -1, 1'b0);
    run(16'h0100, 16'd8, 0, 20, -1, 1'b0);
    run(16'hFFFF, 16'd2, 0, 0, -1, 1'b0);
    run(16'h0200, 16'd4, 0, 0, 4, 1'b0);
    run(16'h0200, 16'd4, 0, 0, -1, 1'b0);

    @(posedge clk); #1;
    base_addr = 16'h0300; word_count = 16'd3; start = 1'b1; m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_outs", {ram_rden, m_valid, busy, done}, 0);
    @(negedge clk);
    rst = 1'b1;
    m_ready = 1'b0;

    run(16'h0300, 16'd3, 0, 0, -1, 1'b0);

    repeat (10) begin
      run(16'($urandom), 16'($urandom_range(0, 7)), 1, 0, -1,
          1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
